// File: rtl/boid_draw_engine.sv
// Boid draw engine: erases the previous square, draws the current one, then steps the updater.
// Optional BOID_DRAW_TRAIL_EN: skip the erase phase so boids leave trails.
module boid_draw_engine #(
   parameter int                   H_RES      = 640,
   parameter int                   V_RES      = 480,
   parameter int                   ADDR_W     = 19,
   parameter int                   COLOR_W    = 8,
   parameter int                   BOID_SIZE  = 2,
   parameter logic [COLOR_W-1:0]   BG_COLOR   = 8'h00,
   parameter logic [COLOR_W-1:0]   BOID_COLOR = 8'hFF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [31:0]         x,
   input  logic [31:0]         y,
   output logic                wr_en,
   input  logic                wr_ready,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [COLOR_W-1:0]  wr_data,
   output logic                acc_en,
   output logic                busy,
   output logic                done
);

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      ERASE,
      DRAW,
      STEP
   } state_t;

   localparam logic [3:0] SZ_M1 = 4'(BOID_SIZE - 1);

   state_t state, state_n;

   logic [15:0] cur_x, cur_y, cur_x_n, cur_y_n;
   logic [15:0] last_x, last_y, last_x_n, last_y_n;
   logic        last_valid, last_valid_n;
   logic [3:0]  dx, dy, dx_n, dy_n;

   logic        pix_adv, pix_last;
   logic [15:0] org_x, org_y;
   logic [16:0] px, py;
   logic        wr_en_n;
   logic [ADDR_W-1:0]  wr_addr_n;
   logic [COLOR_W-1:0] wr_data_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cur_x      <= '0;
         cur_y      <= '0;
         last_x     <= '0;
         last_y     <= '0;
         last_valid <= 1'b0;
         dx         <= '0;
         dy         <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
      end else begin
         state      <= state_n;
         cur_x      <= cur_x_n;
         cur_y      <= cur_y_n;
         last_x     <= last_x_n;
         last_y     <= last_y_n;
         last_valid <= last_valid_n;
         dx         <= dx_n;
         dy         <= dy_n;
         wr_en      <= wr_en_n;
         if (wr_en_n) begin
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
         end
      end
   end

   // A pending write holds the walk until the arbiter takes it.
   always_comb begin
      state_n      = state;
      cur_x_n      = cur_x;
      cur_y_n      = cur_y;
      last_x_n     = last_x;
      last_y_n     = last_y;
      last_valid_n = last_valid;
      dx_n         = dx;
      dy_n         = dy;
      pix_adv      = !wr_en || wr_ready;
      pix_last     = (dx == SZ_M1) && (dy == SZ_M1);
      case (state)
         IDLE: begin
            if (start) state_n = LATCH;
         end
         LATCH: begin
            cur_x_n = x[31:16];
            cur_y_n = y[31:16];
            dx_n    = '0;
            dy_n    = '0;
`ifdef BOID_DRAW_TRAIL_EN
            state_n = DRAW;
`else
            state_n = last_valid ? ERASE : DRAW;
`endif
         end
         ERASE, DRAW: begin
            if (pix_adv) begin
               if (pix_last) begin
                  dx_n    = '0;
                  dy_n    = '0;
                  state_n = (state == ERASE) ? DRAW : STEP;
               end else if (dx == SZ_M1) begin
                  dx_n = '0;
                  dy_n = dy + 4'd1;
               end else begin
                  dx_n = dx + 4'd1;
               end
            end
         end
         STEP: begin
            last_x_n     = cur_x;
            last_y_n     = cur_y;
            last_valid_n = 1'b1;
            state_n      = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are computed from the next walk position so they register in step.
   always_comb begin
      org_x     = (state_n == ERASE) ? last_x : cur_x_n;
      org_y     = (state_n == ERASE) ? last_y : cur_y_n;
      px        = {1'b0, org_x} + {13'b0, dx_n};
      py        = {1'b0, org_y} + {13'b0, dy_n};
      wr_en_n   = ((state_n == ERASE) || (state_n == DRAW))
                  && (px < 17'(H_RES)) && (py < 17'(V_RES));
      wr_addr_n = ADDR_W'(py) * ADDR_W'(H_RES) + ADDR_W'(px);
      wr_data_n = (state_n == ERASE) ? BG_COLOR : BOID_COLOR;
   end

   assign acc_en = (state == STEP);
   assign done   = (state == STEP);
   assign busy   = (state != IDLE);

endmodule

// File: tb/tb_boid_draw_engine.sv
// Directed bench for boid_draw_engine: frame writes, clipping, backpressure, reset.
module tb_boid_draw_engine;

   logic        clk = 1'b0;
   logic        reset, start, wr_ready;
   logic [31:0] x, y;
   logic        wr_en, acc_en, busy, done;
   logic [18:0] wr_addr;
   logic [7:0]  wr_data;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   logic [18:0] q_addr[$];
   logic [7:0]  q_data[$];
   int acc_cnt, acc_cyc, busy_cnt, first_wr_cyc, done_bad, hold_bad;
   logic        prev_hold;
   logic [18:0] prev_addr;
   logic [7:0]  prev_data;

   boid_draw_engine dut (
      .clk(clk), .reset(reset), .start(start), .x(x), .y(y),
      .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .acc_en(acc_en), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (busy) busy_cnt++;
      if (acc_en) begin
         acc_cnt++;
         acc_cyc = cyc;
      end
      if (done !== acc_en) done_bad++;
      if (prev_hold && (wr_en !== 1'b1 || wr_addr !== prev_addr
                        || wr_data !== prev_data)) hold_bad++;
      prev_hold = wr_en && !wr_ready;
      prev_addr = wr_addr;
      prev_data = wr_data;
      if (wr_en === 1'b1 && first_wr_cyc < 0) first_wr_cyc = cyc;
      if (wr_en === 1'b1 && wr_ready) begin
         q_addr.push_back(wr_addr);
         q_data.push_back(wr_data);
      end
   end

   task automatic clear_mon;
      q_addr.delete();
      q_data.delete();
      acc_cnt = 0; acc_cyc = 0; busy_cnt = 0;
      first_wr_cyc = -1; done_bad = 0; hold_bad = 0;
      prev_hold = 1'b0;
   endtask

   task automatic do_reset;
      @(posedge clk); #1;
      reset = 1'b1; start = 1'b0; wr_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic kick(input int px, input int py, output int s);
      @(posedge clk); #1;
      x = px << 16;
      y = py << 16;
      start = 1'b1;
      s = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_acc(input string nm);
      int i;
      for (i = 0; i < 100; i++) begin
         if (acc_cnt != 0) break;
         @(posedge clk); #2;
      end
      n_cmp++;
      if (acc_cnt == 0) begin
         n_bad++;
         $display("FAIL %s timeout: acc_en never seen within 100 cycles", nm);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; wr_ready = 1'b1; x = '0; y = '0;
      clear_mon();
      do_reset();
      n_cmp++;
      if ({wr_en, acc_en, done, busy} !== 4'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b need 0000", {wr_en, acc_en, done, busy});
      end
      n_cmp++;
      if (wr_addr !== 19'd0 || wr_data !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_data: got %0d/%h need 0/00", wr_addr, wr_data);
      end
   endtask

   task automatic test_first_frame;
      int s;
      logic [18:0] ea[4] = '{19'd128180, 19'd128181, 19'd128820, 19'd128821};
      clear_mon();
      kick(180, 200, s);
      wait_acc("first_frame");
      n_cmp++;
      if (q_addr.size() != 4) begin
         n_bad++;
         $display("FAIL first_count: got %0d need 4", q_addr.size());
      end
      for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
         n_cmp++;
         if (q_addr[i] !== ea[i] || q_data[i] !== 8'hFF) begin
            n_bad++;
            $display("FAIL first_wr%0d: got %0d/%h need %0d/ff", i, q_addr[i], q_data[i], ea[i]);
         end
      end
      n_cmp++;
      if (acc_cyc - s != 6 || acc_cnt != 1 || done_bad != 0) begin
         n_bad++;
         $display("FAIL first_acc: lat %0d cnt %0d donebad %0d need 6 1 0", acc_cyc - s, acc_cnt, done_bad);
      end
      n_cmp++;
      if (first_wr_cyc - s != 2 || busy_cnt != 6) begin
         n_bad++;
         $display("FAIL first_timing: firstwr %0d busy %0d need 2 6", first_wr_cyc - s, busy_cnt);
      end
   endtask

   task automatic test_erase_draw;
      int s;
      logic [18:0] ea[8] = '{19'd128180, 19'd128181, 19'd128820, 19'd128821,
                             19'd130744, 19'd130745, 19'd131384, 19'd131385};
      logic [7:0]  ed[8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      clear_mon();
      kick(184, 204, s);
      wait_acc("erase_draw");
      n_cmp++;
      if (q_addr.size() != 8) begin
         n_bad++;
         $display("FAIL erase_count: got %0d need 8", q_addr.size());
      end
      for (int i = 0; i < 8 && i < q_addr.size(); i++) begin
         n_cmp++;
         if (q_addr[i] !== ea[i] || q_data[i] !== ed[i]) begin
            n_bad++;
            $display("FAIL erase_wr%0d: got %0d/%h need %0d/%h", i, q_addr[i], q_data[i], ea[i], ed[i]);
         end
      end
      n_cmp++;
      if (acc_cyc - s != 10 || acc_cnt != 1) begin
         n_bad++;
         $display("FAIL erase_acc: lat %0d cnt %0d need 10 1", acc_cyc - s, acc_cnt);
      end
   endtask

   task automatic test_clip_corner;
      int s;
      do_reset();
      clear_mon();
      kick(639, 479, s);
      wait_acc("clip_corner");
      n_cmp++;
      if (q_addr.size() != 1) begin
         n_bad++;
         $display("FAIL corner_count: got %0d need 1", q_addr.size());
      end else begin
         n_cmp++;
         if (q_addr[0] !== 19'd307199 || q_data[0] !== 8'hFF) begin
            n_bad++;
            $display("FAIL corner_wr: got %0d/%h need 307199/ff", q_addr[0], q_data[0]);
         end
      end
      n_cmp++;
      if (acc_cyc - s != 6) begin
         n_bad++;
         $display("FAIL corner_acc: lat %0d need 6", acc_cyc - s);
      end
   endtask

   task automatic test_negative;
      int s;
      do_reset();
      clear_mon();
      kick(32'hFFFF, 10, s);
      wait_acc("negative");
      n_cmp++;
      if (q_addr.size() != 0 || acc_cnt != 1) begin
         n_bad++;
         $display("FAIL negative: writes %0d acc %0d need 0 1", q_addr.size(), acc_cnt);
      end
      n_cmp++;
      if (acc_cyc - s != 6) begin
         n_bad++;
         $display("FAIL negative_acc: lat %0d need 6", acc_cyc - s);
      end
   endtask

   task automatic test_backpressure;
      int s;
      logic [18:0] ea[4] = '{19'd128180, 19'd128181, 19'd128820, 19'd128821};
      do_reset();
      clear_mon();
      kick(180, 200, s);
      @(posedge clk); #1;
      @(posedge clk); #1;
      wr_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      x = 32'd0;
      y = 32'd0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      wr_ready = 1'b1;
      wait_acc("backpressure");
      repeat (10) @(posedge clk);
      #1;
      n_cmp++;
      if (q_addr.size() != 4) begin
         n_bad++;
         $display("FAIL bp_count: got %0d need 4", q_addr.size());
      end
      for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
         n_cmp++;
         if (q_addr[i] !== ea[i] || q_data[i] !== 8'hFF) begin
            n_bad++;
            $display("FAIL bp_wr%0d: got %0d/%h need %0d/ff", i, q_addr[i], q_data[i], ea[i]);
         end
      end
      n_cmp++;
      if (hold_bad != 0) begin
         n_bad++;
         $display("FAIL bp_hold: got %0d unstable cycles need 0", hold_bad);
      end
      n_cmp++;
      if (acc_cyc - s != 9 || acc_cnt != 1 || busy_cnt != 9 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_acc: lat %0d cnt %0d busy %0d/%b need 9 1 9/0", acc_cyc - s, acc_cnt, busy_cnt, busy);
      end
   endtask

   task automatic test_reset_mid;
      int s;
      do_reset();
      clear_mon();
      kick(180, 200, s);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || wr_en !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_abort: busy %b wr_en %b need 0 0", busy, wr_en);
      end
      clear_mon();
      kick(184, 204, s);
      wait_acc("reset_mid");
      n_cmp++;
      if (q_data.size() != 4 || q_data[0] !== 8'hFF || q_addr[0] !== 19'd130744) begin
         n_bad++;
         $display("FAIL midreset_noerase: writes %0d first %0d/%h need 4 130744/ff",
                  q_data.size(), q_addr.size() ? q_addr[0] : 19'd0, q_data.size() ? q_data[0] : 8'd0);
      end
      n_cmp++;
      if (acc_cyc - s != 6) begin
         n_bad++;
         $display("FAIL midreset_acc: lat %0d need 6", acc_cyc - s);
      end
   endtask

   task automatic test_trail;
      int s, zeros;
      do_reset();
      clear_mon();
      kick(180, 200, s);
      wait_acc("trail_first");
      clear_mon();
      kick(184, 204, s);
      wait_acc("trail_second");
      zeros = 0;
      foreach (q_data[i]) if (q_data[i] == 8'h00) zeros++;
      n_cmp++;
      if (zeros != 0 || q_data.size() != 4 || acc_cyc - s != 6) begin
         n_bad++;
         $display("FAIL trail: zeros %0d writes %0d lat %0d need 0 4 6", zeros, q_data.size(), acc_cyc - s);
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
`ifdef BOID_DRAW_TRAIL_EN
      test_trail();
`else
      test_erase_draw();
`endif
      test_clip_corner();
      test_negative();
      test_backpressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/boid_draw_engine.md
Name: boid_draw_engine

Overview:
- Downstream consumer of the boid position-update stage.
- On each frame tick it erases the boid's previously drawn square from the VGA M10k framebuffer, then draws the square at the current position.
- After drawing, it pulses the update stage's enable so the next position is computed for the following frame.
- It writes to the framebuffer through a valid/ready write port shared with the VGA-side arbiter.

Parameters:
- H_RES, 640, framebuffer width in pixels.
- V_RES, 480, framebuffer height in pixels.
- ADDR_W, 19, framebuffer address width.
- COLOR_W, 8, pixel data width.
- BOID_SIZE, 2, side length of the drawn square in pixels (1..8).
- BG_COLOR, 8'h00, colour written during erase.
- BOID_COLOR, 8'hFF, colour written during draw.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  frame tick, one-cycle pulse.
- x  in  32  current x position, 16.16 unsigned fixed point.
- y  in  32  current y position, 16.16 unsigned fixed point.
- wr_en  out  1  framebuffer write request.
- wr_ready  in  1  arbiter accepts the write this cycle.
- wr_addr  out  ADDR_W  framebuffer address.
- wr_data  out  COLOR_W  pixel colour.
- acc_en  out  1  one-cycle step enable to the position-update stage.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse, coincident with acc_en.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: all outputs 0; state IDLE; last_valid 0; last_x and last_y 0.
- Coordinates: the pixel coordinate is the integer part, bits [31:16], treated as unsigned 16-bit. Negative positions therefore wrap to large values and are clipped.
- States: IDLE, LATCH, ERASE, DRAW, STEP.
- IDLE: start sampled high moves to LATCH. start is ignored in every other state; no queuing.
- LATCH (1 cycle):
  - cur_x = x[31:16], cur_y = y[31:16].
  - dx = dy = 0.
  - Next state is ERASE if last_valid = 1, otherwise DRAW.
- ERASE and DRAW pixel walk:
  - Each phase walks dx 0..BOID_SIZE-1 (fastest), then dy 0..BOID_SIZE-1.
  - Pixel coordinate is origin + (dx, dy). The origin is (last_x, last_y) in ERASE and (cur_x, cur_y) in DRAW.
  - Coordinate arithmetic uses 17 bits so no overflow wraps back in-bounds.
  - A pixel is in-bounds if px < H_RES and py < V_RES.
- In-bounds pixel:
  - wr_en = 1, wr_addr = py*H_RES + px (truncated to ADDR_W), wr_data = BG_COLOR in ERASE or BOID_COLOR in DRAW.
  - Address and data stay stable while wr_en = 1 and wr_ready = 0.
  - The transfer completes on a cycle where wr_en and wr_ready are both high; the counters advance on that edge.
- Out-of-bounds pixel: wr_en = 0 and the counters advance in one cycle (skip cost 1 cycle).
- Registered outputs: wr_en, wr_addr and wr_data are registered. Each pixel occupies at least one cycle.
- Phase end: after the last pixel, ERASE goes to DRAW with dx and dy cleared; DRAW goes to STEP.
- STEP (1 cycle):
  - acc_en = 1, done = 1.
  - last_x = cur_x, last_y = cur_y, last_valid = 1.
  - Next state IDLE.
- Latency, with wr_ready held high and no clipping:
  - The first wr_en cycle is the 2nd cycle after start is sampled.
  - acc_en occurs 2 + 2·BOID_SIZE² cycles after start is sampled (2 + BOID_SIZE² when last_valid = 0).
- Input sampling: x and y are sampled only in LATCH. Changes during ERASE or DRAW have no effect.
- Reset mid-operation: aborts immediately and clears last_valid. The pixels already drawn are not erased (an accepted artefact).
- Simultaneous events: wr_ready high while wr_en is low has no effect. start arriving in the same cycle as STEP is ignored.

Optional Feature:
- Macro: BOID_DRAW_TRAIL_EN.
- Defined: the ERASE state is never entered. LATCH always goes to DRAW, so boids leave trails. last_x, last_y and last_valid still update.
- Undefined: erase-then-draw as specified above.

Test Plan:
- Reset, then start with x=180<<16, y=200<<16, wr_ready=1 (first frame) -> exactly 4 writes to 128180, 128181, 128820, 128821 with data FF; acc_en and done pulse 6 cycles after start; busy is high for that span.
- Second start with x=184<<16, y=204<<16 -> addresses 128180, 128181, 128820, 128821 written with 00, then 130744, 130745, 131384, 131385 written with FF; acc_en 10 cycles after start.
- x=639<<16, y=479<<16 (first frame) -> a single write to 307199; the 3 skipped pixels take 1 cycle each; acc_en 6 cycles after start.
- x=32'hFFFF0000 (negative), y=10<<16 -> zero writes; acc_en still pulses exactly once.
- wr_ready toggled low for 3 cycles during the second pixel -> wr_addr and wr_data held stable, no pixel duplicated or lost, acc_en delayed by exactly 3 cycles; a start pulse during busy is ignored.
- Reset asserted mid-DRAW, followed by a new start -> the next frame performs no erase (first write data is FF). With BOID_DRAW_TRAIL_EN defined, the second frame of the first scenario produces no 00 writes.
